// File: rtl/piso_serializer_if.sv
// Upstream word handshake plus serial frame outputs of the PISO stage.
// master: drives words in and watches the serial side (upstream / bench).
// slave:  the serializer itself.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             in_valid;
  logic             in_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_first;
  logic             sout_last;

  modport master (
    output din, in_valid,
    input  in_ready, sout, sout_valid, sout_first, sout_last
  );

  modport slave (
    input  din, in_valid,
    output in_ready, sout, sout_valid, sout_first, sout_last
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out stage with a one-word holding register so the
// next word can be taken while the current one shifts (zero-gap frames).
// All serial outputs are flops; in_ready is a pure decode of hold_full.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,   // async, active low
  piso_serializer_if.slave     bus
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [WIDTH-1:0] r_shift;      // bits still to be sent, next one at the exit end
  logic [CW-1:0]    r_bit_cnt;    // index of the bit currently on sout
  logic             r_sout;
  logic             r_sout_valid;
  logic             r_sout_first;
  logic             r_sout_last;

  logic             w_at_last;
  logic             w_load;
  logic             w_adv;
  logic             w_accept;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_hold_head;
  logic [WIDTH-1:0] w_hold_rest;
  logic             w_shift_head;
  logic [WIDTH-1:0] w_shift_rest;

  logic [WIDTH-1:0] w_shift_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_sout_nxt;
  logic             w_valid_nxt;
  logic             w_first_nxt;
  logic             w_last_nxt;

  // Bit-order selection: the "head" is the bit that goes out next.
  assign w_hold_head  = MSB_FIRST ? r_hold[WIDTH-1]  : r_hold[0];
  assign w_hold_rest  = MSB_FIRST ? (r_hold << 1)    : (r_hold >> 1);
  assign w_shift_head = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
  assign w_shift_rest = MSB_FIRST ? (r_shift << 1)   : (r_shift >> 1);

  // Frame control decodes. A load happens from IDLE or exactly at the end of
  // a frame, which is what makes back-to-back frames gapless.
  assign w_at_last = (r_state == SHIFT) && (r_bit_cnt == LAST_IDX);
  assign w_load    = r_hold_full && ((r_state == IDLE) || w_at_last);
  assign w_adv     = (r_state == SHIFT) && !w_at_last;
  assign w_cnt_inc = r_bit_cnt + 1'b1;

  // Accept only uses the registered ready, so no in_valid -> in_ready path.
  // On a load edge hold_full is still 1, so nothing is accepted that edge.
  assign w_accept  = bus.in_valid && !r_hold_full;

  assign bus.in_ready   = !r_hold_full;
  assign bus.sout       = r_sout;
  assign bus.sout_valid = r_sout_valid;
  assign bus.sout_first = r_sout_first;
  assign bus.sout_last  = r_sout_last;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM next-state: leave IDLE on a pending word, return when a frame ends dry.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (r_hold_full)                  w_state_nxt = SHIFT;
      SHIFT:   if (w_at_last && !r_hold_full)    w_state_nxt = IDLE;
      default:                                   w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: next values for the shifter, bit counter and serial flops.
  always_comb begin
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_bit_cnt;
    w_sout_nxt  = 1'b0;
    w_valid_nxt = 1'b0;
    w_first_nxt = 1'b0;
    w_last_nxt  = 1'b0;
    if (w_load) begin
      // First bit leaves straight from the holding register.
      w_shift_nxt = w_hold_rest;
      w_cnt_nxt   = '0;
      w_sout_nxt  = w_hold_head;
      w_valid_nxt = 1'b1;
      w_first_nxt = 1'b1;
    end else if (w_adv) begin
      w_shift_nxt = w_shift_rest;
      w_cnt_nxt   = w_cnt_inc;
      w_sout_nxt  = w_shift_head;
      w_valid_nxt = 1'b1;
      w_last_nxt  = (w_cnt_inc == LAST_IDX);
    end
  end

  // Holding register: filled on accept, freed when moved into the shifter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold      <= bus.din;
      r_hold_full <= 1'b1;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  // Shifter, bit counter and registered serial outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_sout_first <= 1'b0;
      r_sout_last  <= 1'b0;
    end else begin
      r_shift      <= w_shift_nxt;
      r_bit_cnt    <= w_cnt_nxt;
      r_sout       <= w_sout_nxt;
      r_sout_valid <= w_valid_nxt;
      r_sout_first <= w_first_nxt;
      r_sout_last  <= w_last_nxt;
    end
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in/serial-out stage directly downstream of the 4-bit buffer register. It consumes the registered word q through a valid/ready handshake and shifts it out one bit per clock with frame markers. A one-word holding register lets the next word be accepted while the current one shifts, so back-to-back frames leave no idle cycle.

Parameters:
WIDTH, 4, word width in bits; legal values are 2..16.
MSB_FIRST, 0, bit order: 0 sends the LSB first, 1 sends the MSB first.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset; rst=0 clears all state immediately.
din  input  WIDTH  parallel word, driven from the buffer register output q.
in_valid  input  1  din holds a word to transfer.
in_ready  output  1  holding register is empty and can accept a word.
sout  output  1  serial data bit.
sout_valid  output  1  sout carries a frame bit.
sout_first  output  1  high during the first bit of a frame.
sout_last  output  1  high during the last bit of a frame.

Behaviour:
- Reset (rst=0, asynchronous):
  - Shift register, holding register and bit counter are cleared; hold_full=0; state=IDLE.
  - sout=0, sout_valid=0, sout_first=0, sout_last=0, in_ready=1.
  - Takes effect mid-frame: the current frame and any held word are discarded. The first frame after reset release starts cleanly.
- in_ready = !hold_full, decoded combinationally from a register. It has no combinational path from in_valid.
- Accept: on a rising edge with in_valid=1 and in_ready=1, din is written to the holding register and hold_full becomes 1. When in_ready=0, in_valid is ignored and din is not sampled.
- Registered outputs: sout, sout_valid, sout_first and sout_last are all flops.
- States:
  - IDLE: sout_valid=0, sout=0. On an edge with hold_full=1: hold→shifter, hold_full→0, bit_cnt→0, state→SHIFT, sout_valid=1, sout_first=1, sout=first bit.
  - SHIFT: each edge advances one bit and increments bit_cnt. sout_first=1 only while bit_cnt=0. sout_last=1 only while bit_cnt=WIDTH-1.
  - End of frame: on the edge that leaves bit_cnt=WIDTH-1:
    - if hold_full=1, the next word is loaded immediately (bit_cnt→0, sout_first=1, hold_full→0, stay in SHIFT), giving zero gap;
    - otherwise, go to IDLE with sout_valid=0, sout=0, sout_last=0.
- Latency: a word accepted at edge N is transferred at edge N+1 if the shifter is idle. Its first bit is visible after edge N+1. The last bit is visible after edge N+WIDTH. sout_valid drops after edge N+WIDTH+1 if nothing is pending.
- Bit order:
  - MSB_FIRST=0: bit k of a frame is din[k].
  - MSB_FIRST=1: bit k of a frame is din[WIDTH-1-k].
- Simultaneous load and accept: the holding register is freed on the transfer edge, but in_ready was 0 on that edge, so no word is accepted then. The earliest next accept is the following edge.
- Throughput: sustained rate is one word per WIDTH cycles. in_ready is low for WIDTH-1 cycles per frame under continuous in_valid.
- A word held in the holding register is never overwritten or dropped until it is transferred, except by reset.
- Serial-side backpressure: none. The downstream consumer must accept one bit per cycle while sout_valid=1.

Test Plan:
1. Reset check: hold rst=0 for 15 ns, then release. Outputs read sout_valid=0, sout=0, in_ready=1. Asserting rst=0 asynchronously mid-cycle clears the outputs before the next clk edge.
2. Single frame, LSB-first: din=4'b1101 with a one-cycle in_valid pulse. sout reads 1,0,1,1 on the next 4 cycles, with sout_first on the 1st bit, sout_last on the 4th, and sout_valid=0 on the 5th.
3. Back-to-back frames: din=4'hA then 4'h5, with in_valid held high. sout reads 0,1,0,1,1,0,1,0 with no gap. sout_first pulses at bits 0 and 4. in_ready is low while the second word is held.
4. Reset mid-frame: issue din=4'hF, then pull rst=0 after 2 bits while 4'h3 is held. Both frames are lost. After release, sending din=4'h6 alone yields 0,1,1,0.
5. MSB_FIRST=1 build: din=4'b1000 gives 1,0,0,0; din=4'b0011 gives 0,0,1,1.
6. Sweep din=0..15 with in_valid pulsed each time in_ready=1. The bench reconstructs each 4-bit word from sout and checks that all 16 arrive in order with none missing or duplicated.
